// File: rtl/fp_pkg.sv
// rtl/fp_pkg.sv - shared IEEE-754 single-precision constants, operand classes and classifier
package fp_pkg;

  localparam int FP_BIAS  = 127;
  localparam int FP_EXP_W = 8;
  localparam int FP_MAN_W = 23;

  localparam logic [31:0] FP_CANON_NAN = 32'h7FC00000;
  localparam logic [31:0] FP_POS_INF   = 32'h7F800000;

  // Operand class; denormals are folded into ZERO (flush-to-zero on input)
  typedef enum logic [1:0] {
    ZERO = 2'd0,
    NORM = 2'd1,
    INF  = 2'd2,
    NAN  = 2'd3
  } fp_class_t;

  // Classify one operand from its exponent and fraction fields
  function automatic fp_class_t fp_classify(input logic [FP_EXP_W-1:0] exp_f,
                                            input logic [FP_MAN_W-1:0] man_f);
    fp_class_t cls;
    if (exp_f == '0) begin
      cls = ZERO;
    end else if (exp_f == '1) begin
      cls = (man_f == '0) ? INF : NAN;
    end else begin
      cls = NORM;
    end
    return cls;
  endfunction

endpackage

// File: rtl/fp_mul_round.sv
// rtl/fp_mul_round.sv - combinational normalize/round/pack stage (FP_MUL_RNE_EN selects round-nearest-even, else truncate)
module fp_mul_round
  import fp_pkg::*;
(
  input  logic              sign,
  input  logic signed [9:0] exp,
  input  logic [47:0]       prod,
  input  fp_class_t         cls_a,
  input  fp_class_t         cls_b,
  output logic [31:0]       result
);

`ifdef FP_MUL_RNE_EN
  localparam logic RNE_EN = 1'b1;
`else
  localparam logic RNE_EN = 1'b0;
`endif

  logic              norm_hi;
  logic [23:0]       sig_n;
  logic              guard;
  logic              sticky;
  logic              round_up;
  logic [24:0]       sig_r;
  logic signed [9:0] exp_n;
  logic [FP_MAN_W-1:0] frac;
  logic              is_nan;
  logic              is_inf;
  logic              is_zero;

  // Normalize the [1,4) product, round on guard/sticky, renormalize on carry-out, then pack by class
  always_comb begin
    norm_hi  = prod[47];
    sig_n    = norm_hi ? prod[47:24] : prod[46:23];
    guard    = norm_hi ? prod[23] : prod[22];
    sticky   = norm_hi ? (|prod[22:0]) : (|prod[21:0]);
    // Ties go up only when the kept LSB is odd, giving round-half-even
    round_up = RNE_EN & guard & (sticky | sig_n[0]);
    sig_r    = {1'b0, sig_n} + {24'd0, round_up};
    exp_n    = exp + $signed({9'd0, norm_hi}) + $signed({9'd0, sig_r[24]});
    frac     = sig_r[24] ? sig_r[23:1] : sig_r[22:0];

    is_nan   = (cls_a == NAN) || (cls_b == NAN) ||
               ((cls_a == ZERO) && (cls_b == INF)) ||
               ((cls_a == INF) && (cls_b == ZERO));
    is_inf   = (cls_a == INF) || (cls_b == INF);
    is_zero  = (cls_a == ZERO) || (cls_b == ZERO);

    result = 32'd0;
    if (is_nan) begin
      result = FP_CANON_NAN;
    end else if (is_inf) begin
      result = FP_POS_INF | {sign, 31'd0};
    end else if (is_zero) begin
      result = {sign, 31'd0};
    end else if (exp_n >= 10'sd255) begin
      result = FP_POS_INF | {sign, 31'd0};
    end else if (exp_n <= 10'sd0) begin
      // No denormal outputs: underflow goes straight to signed zero
      result = {sign, 31'd0};
    end else begin
      result = {sign, exp_n[FP_EXP_W-1:0], frac};
    end
  end

endmodule

// File: rtl/fp_mul_pipe.sv
// rtl/fp_mul_pipe.sv - 3-stage IEEE-754 single multiplier with valid/ready flow control (FP_MUL_RNE_EN enables RNE rounding)
module fp_mul_pipe
  import fp_pkg::*;
(
  input  logic        clk,
  input  logic        clear,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a_in,
  input  logic [31:0] b_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] prod_out
);

  localparam logic signed [9:0] EXP_BIAS = 10'(FP_BIAS);

  // Whole pipe moves as one: any stage loads only when the output slot is free or being drained
  logic advance;
  assign advance  = ~out_valid | out_ready;
  assign in_ready = advance;

  // Operand unpack with denormal flush: non-normal classes contribute a zero mantissa
  fp_class_t   cls_a;
  fp_class_t   cls_b;
  logic [23:0] mant_a;
  logic [23:0] mant_b;
  logic [35:0] pp_lo;

  assign cls_a  = fp_classify(a_in[30:23], a_in[22:0]);
  assign cls_b  = fp_classify(b_in[30:23], b_in[22:0]);
  assign mant_a = (cls_a == NORM) ? {1'b1, a_in[22:0]} : 24'd0;
  assign mant_b = (cls_b == NORM) ? {1'b1, b_in[22:0]} : 24'd0;
  assign pp_lo  = {12'd0, mant_a} * {24'd0, mant_b[11:0]};

  // Stage 1 registers
  logic              s1_valid;
  logic              s1_sign;
  logic signed [9:0] s1_exp;
  fp_class_t         s1_cls_a;
  fp_class_t         s1_cls_b;
  logic [23:0]       s1_mant_a;
  logic [11:0]       s1_mant_b_hi;
  logic [35:0]       s1_pp_lo;

  // S1: capture sign, biased exponent sum, classes and the low partial product
  always_ff @(posedge clk) begin
    if (clear) begin
      s1_valid     <= 1'b0;
      s1_sign      <= 1'b0;
      s1_exp       <= '0;
      s1_cls_a     <= ZERO;
      s1_cls_b     <= ZERO;
      s1_mant_a    <= '0;
      s1_mant_b_hi <= '0;
      s1_pp_lo     <= '0;
    end else if (advance) begin
      s1_valid <= in_valid;
      // Data only loads with a real operand so idle-bus garbage never enters the pipe
      if (in_valid) begin
        s1_sign      <= a_in[31] ^ b_in[31];
        s1_exp       <= $signed({2'b00, a_in[30:23]}) + $signed({2'b00, b_in[30:23]}) - EXP_BIAS;
        s1_cls_a     <= cls_a;
        s1_cls_b     <= cls_b;
        s1_mant_a    <= mant_a;
        s1_mant_b_hi <= mant_b[23:12];
        s1_pp_lo     <= pp_lo;
      end
    end
  end

  // High partial product and the full 48-bit significand product
  logic [35:0] pp_hi;
  logic [47:0] prod_sum;

  assign pp_hi    = {12'd0, s1_mant_a} * {24'd0, s1_mant_b_hi};
  assign prod_sum = {pp_hi, 12'd0} + {12'd0, s1_pp_lo};

  // Stage 2 registers
  logic              s2_valid;
  logic              s2_sign;
  logic signed [9:0] s2_exp;
  fp_class_t         s2_cls_a;
  fp_class_t         s2_cls_b;
  logic [47:0]       s2_prod;

  // S2: finish the multiply and carry sign/exponent/classes alongside
  always_ff @(posedge clk) begin
    if (clear) begin
      s2_valid <= 1'b0;
      s2_sign  <= 1'b0;
      s2_exp   <= '0;
      s2_cls_a <= ZERO;
      s2_cls_b <= ZERO;
      s2_prod  <= '0;
    end else if (advance) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_sign  <= s1_sign;
        s2_exp   <= s1_exp;
        s2_cls_a <= s1_cls_a;
        s2_cls_b <= s1_cls_b;
        s2_prod  <= prod_sum;
      end
    end
  end

  // S3 normalize/round/pack lives in its own block so other datapaths can reuse it
  logic [31:0] round_result;

  fp_mul_round u_round (
    .sign   (s2_sign),
    .exp    (s2_exp),
    .prod   (s2_prod),
    .cls_a  (s2_cls_a),
    .cls_b  (s2_cls_b),
    .result (round_result)
  );

  // S3: output register; a bubble clears out_valid but leaves the last product in place
  always_ff @(posedge clk) begin
    if (clear) begin
      out_valid <= 1'b0;
      prod_out  <= 32'd0;
    end else if (advance) begin
      out_valid <= s2_valid;
      if (s2_valid) begin
        prod_out <= round_result;
      end
    end
  end

endmodule

// File: tb/tb_fp_mul_pipe.sv
// tb/tb_fp_mul_pipe.sv - self-checking bench for fp_mul_pipe (honours FP_MUL_RNE_EN)
module tb_fp_mul_pipe;

`ifdef FP_MUL_RNE_EN
  localparam bit RNE = 1'b1;
`else
  localparam bit RNE = 1'b0;
`endif

  localparam int NRAND = 10000;

  logic        clk = 1'b0;
  logic        clear;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a_in;
  logic [31:0] b_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] prod_out;

  int n_total = 0;
  int n_pass  = 0;

  fp_mul_pipe dut (
    .clk       (clk),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_in      (a_in),
    .b_in      (b_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .prod_out  (prod_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
    n_total++;
    if (got === expv) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", tag, got, expv);
  endtask

  // Independent reference: full-width product, remainder-vs-half rounding
  function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
    logic   s;
    logic   za, zb, ia, ib, na, nb;
    int     e;
    longint p, keep, rem, half;
    s  = a[31] ^ b[31];
    za = (a[30:23] == 8'h00);
    zb = (b[30:23] == 8'h00);
    ia = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
    ib = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
    na = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
    nb = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
    if (na || nb || (za && ib) || (ia && zb)) return 32'h7FC00000;
    if (ia || ib) return {s, 8'hFF, 23'd0};
    if (za || zb) return {s, 31'd0};
    p = longint'({1'b1, a[22:0]}) * longint'({1'b1, b[22:0]});
    e = int'(a[30:23]) + int'(b[30:23]) - 127;
    if (p[47]) begin
      e++;
      keep = p >> 24;
      rem  = p & 64'hFFFFFF;
      half = 64'h800000;
    end else begin
      keep = p >> 23;
      rem  = p & 64'h7FFFFF;
      half = 64'h400000;
    end
    if (RNE && ((rem > half) || ((rem == half) && keep[0]))) keep++;
    if (keep == 64'h1000000) begin
      keep = keep >> 1;
      e++;
    end
    if (e >= 255) return {s, 8'hFF, 23'd0};
    if (e <= 0) return {s, 31'd0};
    return {s, 8'(e), keep[22:0]};
  endfunction

  function automatic logic [31:0] rnd_op();
    logic [31:0] r;
    int k;
    r = $urandom;
    k = $urandom_range(0, 15);
    case (k)
      0:       r[30:23] = 8'h00;
      1:       r[30:23] = 8'hFF;
      2:       r[30:0]  = {8'hFF, 23'd0};
      3:       r[30:0]  = 31'd0;
      default: r[30:23] = 8'($urandom_range(40, 214));
    endcase
    return r;
  endfunction

  // One isolated operation on a drained pipe; checks value and acceptance-to-output latency
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] expv);
    int lat;
    in_valid  = 1'b1;
    a_in      = a;
    b_in      = b;
    out_ready = 1'b1;
    @(negedge clk);
    check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    a_in     = 32'hDEADBEEF;
    b_in     = 32'h7FFFFFFF;
    lat = 1;
    while (!out_valid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_lat"}, lat, 32'd3);
    check({tag, "_val"}, prod_out, expv);
    @(posedge clk); #1;
  endtask

  logic [31:0] qa [4];
  logic [31:0] qb [4];
  logic [31:0] qe [4];
  int          outcyc [4];
  logic [31:0] sb [$];

  initial begin
    int nin, nout, nres, cyc;
    clear     = 1'b1;
    in_valid  = 1'b0;
    a_in      = 32'd0;
    b_in      = 32'd0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_prod_out", prod_out, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    clear = 1'b0;

    // Directed vectors
    run_op("mul_1p5x2", 32'h3FC00000, 32'h40000000, 32'h40400000);
    run_op("round_lsb", 32'h3FC00001, 32'h3FC00000, RNE ? 32'h40100001 : 32'h40100000);
    run_op("overflow", 32'h7F000000, 32'h40000000, 32'h7F800000);
    run_op("underflow", 32'h00800000, 32'h00800000, 32'h00000000);
    run_op("zero_x_inf", 32'h00000000, 32'hFF800000, 32'h7FC00000);
    run_op("neg2_x_3", 32'hC0000000, 32'h40400000, 32'hC0C00000);
    run_op("inf_x_neg2", 32'h7F800000, 32'hC0000000, 32'hFF800000);
    run_op("denorm_flush", 32'h00000001, 32'hC0A00000, 32'h80000000);
    run_op("nan_x_one", 32'h7FA00000, 32'h3F800000, 32'h7FC00000);
    run_op("one_x_one", 32'h3F800000, 32'h3F800000, 32'h3F800000);
    run_op("big_frac", 32'h3FFFFFFF, 32'h3FFFFFFF, 32'h407FFFFE);
    run_op("neg_sq", 32'h3FC00000, 32'hBFC00000, 32'hC0100000);

    // Back-pressure: four back-to-back pairs, consumer stalls from the second cycle
    qa = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000};
    qb = '{32'h40000000, 32'h40000000, 32'h40000000, 32'h40000000};
    qe = '{32'h40000000, 32'h40800000, 32'h40C00000, 32'h41000000};
    nin = 0;
    nout = 0;
    for (int c = 0; c < 40 && nout < 4; c++) begin
      out_ready = !(c >= 1 && c < 8);
      in_valid  = (nin < 4);
      a_in      = qa[nin % 4];
      b_in      = qb[nin % 4];
      @(negedge clk);
      if (c == 6) check("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
      if (c == 6) check("bp_out_hold", prod_out, qe[0]);
      if (out_valid && out_ready) begin
        check($sformatf("bp_res%0d", nout), prod_out, qe[nout]);
        outcyc[nout] = c;
        nout++;
      end
      if (in_valid && in_ready) nin++;
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check("bp_count", nout, 32'd4);
    if (nout == 4) check("bp_one_per_cycle", outcyc[3] - outcyc[0], 32'd3);
    @(posedge clk); #1;

    // Clear with two operations in flight
    in_valid = 1'b1;
    a_in = 32'h3FC00000;
    b_in = 32'h40000000;
    @(posedge clk); #1;
    a_in = 32'h40400000;
    b_in = 32'h40400000;
    @(posedge clk); #1;
    in_valid = 1'b0;
    clear    = 1'b1;
    @(posedge clk); #1;
    check("clr_out_valid", {31'd0, out_valid}, 32'd0);
    check("clr_prod_out", prod_out, 32'd0);
    check("clr_in_ready", {31'd0, in_ready}, 32'd1);
    clear    = 1'b0;
    in_valid = 1'b1;
    a_in     = 32'h40000000;
    b_in     = 32'h40800000;
    @(negedge clk);
    check("clr_accept_first", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    nres = 0;
    for (int i = 1; i <= 8; i++) begin
      if (out_valid) begin
        nres++;
        check("clr_new_val", prod_out, 32'h41000000);
        check("clr_new_lat", i, 32'd3);
      end
      @(posedge clk); #1;
    end
    check("clr_result_count", nres, 32'd1);

    // Random stream with random valid/ready against the reference model
    nin = 0;
    nout = 0;
    cyc = 0;
    while (nout < NRAND && cyc < 80000) begin
      in_valid  = (nin < NRAND) && ($urandom_range(0, 3) != 0);
      a_in      = rnd_op();
      b_in      = rnd_op();
      out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (out_valid && out_ready) begin
        if (sb.size() > 0) check("rand_result", prod_out, sb.pop_front());
        else check("rand_spurious", sb.size(), 32'd1);
        nout++;
      end
      if (in_valid && in_ready) begin
        sb.push_back(ref_mul(a_in, b_in));
        nin++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    check("rand_count", nout, NRAND);
    check("rand_drained", sb.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/fp_mul_pipe.md
FP_MUL_PIPE -- requirements
Module: fp_mul_pipe

Interface
REQ-001 SHALL have ports: clk  input  1  rising-edge clock for all state.
REQ-002 SHALL have ports: clear  input  1  synchronous active-high reset.
REQ-003 SHALL have ports: in_valid  input  1  operand pair a_in/b_in is valid.
REQ-004 SHALL have ports: in_ready  output  1  block accepts a pair this cycle.
REQ-005 SHALL have ports: a_in  input  32  IEEE-754 single operand A.
REQ-006 SHALL have ports: b_in  input  32  IEEE-754 single operand B.
REQ-007 SHALL have ports: out_valid  output  1  prod_out holds a result.
REQ-008 SHALL have ports: out_ready  input  1  consumer takes the result this cycle.
REQ-009 SHALL have ports: prod_out  output  32  IEEE-754 single product.
REQ-010 SHALL use one clock, clk; reset clear is synchronous and active-high.

Function
REQ-011 SHALL be a 3-stage pipeline. S1: unpack, sign XOR, exponent sum minus 127, operand classification, and the partial product mant_a*mant_b[11:0]. S2: the partial product mant_a*mant_b[23:12], then the 48-bit sum. S3: normalize, round, pack into the output register.
REQ-012 SHALL set advance = ~out_valid | out_ready; all stages load only when advance=1, and in_ready = advance.
REQ-013 SHALL accept a pair when in_valid & in_ready; with out_ready held 1, the result SHALL appear with out_valid=1 exactly 3 cycles after acceptance.
REQ-014 SHALL, when out_valid=1 and out_ready=0, freeze all stage registers and prod_out; no result SHALL be lost or duplicated.
REQ-015 SHALL propagate bubbles as valid=0 stages; bubbles are not collapsed.
REQ-016 SHALL flush denormal inputs to signed zero before multiplication.
REQ-017 SHALL produce results by class:
- either operand NaN, or zero*Inf: 0x7FC00000.
- Inf*finite-nonzero: signed Inf.
- zero*finite: signed zero.
REQ-018 SHALL normalize product bit 47 by shifting right 1 and incrementing the exponent; rounding carry-out SHALL renormalize likewise.
REQ-019 SHALL use a 10-bit signed exponent internally.
- Final exponent >=255: signed Inf (0x7F800000 | sign).
- Final exponent <=0: signed zero (no denormal output).
REQ-020 SHALL ignore a_in/b_in when in_valid=0; X on data SHALL NOT reach valid outputs.

Reset
REQ-021 SHALL on clear=1 clear all stage valids, out_valid=0, prod_out=0x00000000, in_ready=1 at the next edge.
REQ-022 SHALL discard any in-flight operations when clear asserts mid-operation; no stale result after release.
REQ-023 SHALL accept input on the first cycle after clear deasserts.

Configuration
REQ-024 SHALL, when macro FP_MUL_RNE_EN is defined, round to nearest, ties to even, using guard/round/sticky from product bits below the LSB.
REQ-025 SHALL, when FP_MUL_RNE_EN is undefined, truncate (round toward zero); latency SHALL be 3 cycles in both builds.

Structure
REQ-026 SHALL take from shared package fp_pkg:
- constants FP_BIAS=127, FP_EXP_W=8, FP_MAN_W=23, FP_CANON_NAN=32'h7FC00000, FP_POS_INF=32'h7F800000.
- operand class enum {ZERO, NORM, INF, NAN}.
REQ-027 SHALL instantiate one sub-module fp_mul_round (S3 normalize/round/pack, combinational) so the later divider output stage can reuse it.

Verification
REQ-028 SHALL cover: 0x3FC00000 * 0x40000000 (1.5*2.0), out_ready=1 -> prod_out=0x40400000 exactly 3 cycles after acceptance.
REQ-029 SHALL cover: 0x3FC00001 * 0x3FC00000 -> 0x40100001 with FP_MUL_RNE_EN, 0x40100000 without.
REQ-030 SHALL cover:
- 0x7F000000 * 0x40000000 -> 0x7F800000.
- 0x00800000 * 0x00800000 -> 0x00000000.
- 0x00000000 * 0xFF800000 -> 0x7FC00000.
REQ-031 SHALL cover: 4 back-to-back pairs with out_ready=0 from cycle 2 -> in_ready=0 after the pipe fills; releasing out_ready yields all 4 results in order, one per cycle.
REQ-032 SHALL cover: clear pulsed 1 cycle with 2 ops in flight -> out_valid=0 and prod_out=0 next cycle; a new op after release returns only its own result 3 cycles later.
REQ-033 SHALL cover: a random 10k-pair stream with random in_valid/out_ready against a reference model -> bit-exact match, order preserved.
